// File: rtl/pwm_deadtime_pkg.sv
// Shared definitions for the complementary-output dead-time generator:
// register offsets, FSM encodings and register field positions.
package pwm_deadtime_pkg;

  localparam logic [7:0] DT_CTRL = 8'h00;
  localparam logic [7:0] DT_TIME = 8'h04;
  localparam logic [7:0] DT_STAT = 8'h08;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LO_ON   = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HI_ON   = 3'd3,
    ST_DT_FALL = 3'd4,
    ST_FAULT   = 3'd5
  } dt_state_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_HI_POL_BIT = 1;
  localparam int CTRL_LO_POL_BIT = 2;
  localparam int CTRL_IRQ_EN_BIT = 3;

  localparam int TIME_RISE_LSB = 0;
  localparam int TIME_FALL_LSB = 16;

  localparam int STAT_FAULT_BIT = 0;
  localparam int STAT_STATE_LSB = 1;
  localparam int STAT_PWM_BIT   = 4;
  localparam int STAT_BRK_BIT   = 5;

endpackage

// File: rtl/pwm_deadtime_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous levels into clk.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_reg[gi] <= 1'b0;
        sync_reg[gi] <= 1'b0;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time generator: turns the timer compare output into a non-overlapping
// high-side/low-side gate pair with a break input that latches a fault.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  input  logic        pwm_i,
  input  logic        brk_i,
  output logic        pwm_hi_o,
  output logic        pwm_lo_o,
  output logic        irq_fault_o
);

  logic [3:0]  ctrl_reg;
  logic [15:0] dt_rise_reg;
  logic [15:0] dt_fall_reg;
  logic        fault_reg, fault_next;
  logic        pwm_q;
  logic        brk_s;
  dt_state_e   state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        hi_reg, lo_reg, irq_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic        enable;
  logic        stat_w1c;
  logic        unused_sel;

  // Byte selects carry no meaning here: every write is a full word.
  assign unused_sel = ^sel_i;

  assign enable   = ctrl_reg[CTRL_EN_BIT];
  assign stat_w1c = we_i && (waddr_i == DT_STAT) && data_i[STAT_FAULT_BIT];

  sync2 #(.WIDTH(1)) u_brk_sync (
    .clk (clk),
    .rst (rst),
    .d   (brk_i),
    .q   (brk_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg    <= '0;
      dt_rise_reg <= '0;
      dt_fall_reg <= '0;
    end else if (we_i) begin
      case (waddr_i)
        DT_CTRL: ctrl_reg <= data_i[3:0];
        DT_TIME: begin
          dt_rise_reg <= data_i[TIME_RISE_LSB +: 16];
          dt_fall_reg <= data_i[TIME_FALL_LSB +: 16];
        end
        default: ;
      endcase
    end
  end

  // A live break wins over a simultaneous clear so the fault cannot be lost.
  always_comb begin
    fault_next = fault_reg;
    if (stat_w1c) fault_next = 1'b0;
    if (brk_s)    fault_next = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (brk_s) begin
      state_next = ST_FAULT;
      cnt_next   = '0;
    end else if (state_reg == ST_FAULT) begin
      if (!fault_reg) state_next = ST_IDLE;
    end else if (!enable) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (!pwm_q) state_next = ST_LO_ON;
        ST_LO_ON: begin
          if (pwm_q) begin
            if (dt_rise_reg == '0) begin
              state_next = ST_HI_ON;
            end else begin
              state_next = ST_DT_RISE;
              cnt_next   = 16'd1;
            end
          end
        end
        // Gap compare uses the live register so mid-gap rewrites apply at once.
        ST_DT_RISE: begin
          if (!pwm_q) begin
            state_next = ST_LO_ON;
            cnt_next   = '0;
          end else if (cnt_reg >= dt_rise_reg) begin
            state_next = ST_HI_ON;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
        ST_HI_ON: begin
          if (!pwm_q) begin
            if (dt_fall_reg == '0) begin
              state_next = ST_LO_ON;
            end else begin
              state_next = ST_DT_FALL;
              cnt_next   = 16'd1;
            end
          end
        end
        ST_DT_FALL: begin
          if (pwm_q) begin
            state_next = ST_HI_ON;
            cnt_next   = '0;
          end else if (cnt_reg >= dt_fall_reg) begin
            state_next = ST_LO_ON;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      fault_reg <= 1'b0;
      pwm_q     <= 1'b0;
      hi_reg    <= 1'b0;
      lo_reg    <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      fault_reg <= fault_next;
      pwm_q     <= pwm_i;
      // Gate flops follow the next-state decode so they move with the state.
      hi_reg    <= (state_next == ST_HI_ON) ^ ctrl_reg[CTRL_HI_POL_BIT];
      lo_reg    <= (state_next == ST_LO_ON) ^ ctrl_reg[CTRL_LO_POL_BIT];
      irq_reg   <= !fault_reg && fault_next && ctrl_reg[CTRL_IRQ_EN_BIT];
    end
  end

  always_comb begin
    rdata_next = '0;
    case (raddr_i)
      DT_CTRL: rdata_next[3:0] = ctrl_reg;
      DT_TIME: rdata_next = {dt_fall_reg, dt_rise_reg};
      DT_STAT: begin
        rdata_next[STAT_FAULT_BIT]      = fault_reg;
        rdata_next[STAT_STATE_LSB +: 3] = state_reg;
        rdata_next[STAT_PWM_BIT]        = pwm_q;
        rdata_next[STAT_BRK_BIT]        = brk_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (rd_i) begin
      rdata_reg <= rdata_next;
    end
  end

  assign data_o      = rdata_reg;
  assign pwm_hi_o    = hi_reg;
  assign pwm_lo_o    = lo_reg;
  assign irq_fault_o = irq_reg;

endmodule

// File: doc/pwm_deadtime.md
# pwm_deadtime

Complementary-output dead-time generator placed directly downstream of the system timer: it consumes the timer's positive compare output and drives a high-side/low-side gate pair that never overlap. Each edge of the input waveform gets a programmable both-off gap. An asynchronous break input forces both outputs inactive and latches a fault. The block is programmed over the same 8-bit-offset peripheral register bus as the timer and raises a one-cycle fault interrupt pulse.

## Interface
- No parameters; data bus is 32 bits (`MemBus`).
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- waddr_i  in  8  write register offset.
- data_i  in  32  write data.
- sel_i  in  4  byte selects; ignored, every write is full-word.
- we_i  in  1  write strobe.
- raddr_i  in  8  read register offset.
- rd_i  in  1  read strobe.
- data_o  out  32  read data, registered; holds its value when rd_i=0.
- pwm_i  in  1  timer compare output (timer_cmpo_p); synchronous to clk.
- brk_i  in  1  external break input, asynchronous, active-high.
- pwm_hi_o  out  1  high-side gate drive.
- pwm_lo_o  out  1  low-side gate drive.
- irq_fault_o  out  1  fault interrupt, one-cycle pulse.

## Operation
- DT_CTRL 0x00: [0] enable, [1] hi polarity, [2] lo polarity, [3] fault irq enable, [31:4] RO 0. A polarity bit of 0 makes that output active-high; 1 makes it active-low. Inactive level = polarity bit.
- DT_TIME 0x04: [15:0] dt_rise, the both-off gap before hi turns on. [31:16] dt_fall, the both-off gap before lo turns on. Both are in clk cycles.
- DT_STAT 0x08: [0] fault latched (write 1 to clear). [3:1] FSM state (RO). [4] pwm_q (RO). [5] synchronized brk (RO).
- Reads from any other offset return 0. Writes to any other offset are ignored. All registers reset to 0.
- pwm_i is registered once into pwm_q. brk_i passes through a 2-flop synchronizer to give brk_s.
- FSM states: IDLE=0, LO_ON=1, DT_RISE=2, HI_ON=3, DT_FALL=4, FAULT=5.
- IDLE: both outputs inactive. Go to LO_ON when enable=1 and pwm_q=0. Stay in IDLE while pwm_q=1.
- LO_ON: lo active. When pwm_q=1, go to DT_RISE, or directly to HI_ON if dt_rise=0.
- DT_RISE: both outputs off. Go to HI_ON when cnt>=dt_rise. If pwm_q=0 first, return to LO_ON; this swallows pulses shorter than the dead time.
- HI_ON / DT_FALL: mirror of LO_ON / DT_RISE, using pwm_q=0 and dt_fall.
- cnt (16 bit): loads 1 on entry to a DT state and increments each cycle in that state. The comparison is live, so rewriting DT_TIME mid-gap takes effect immediately. If cnt is already >= the new value, the gap ends at the next edge.
- enable=0 from any non-FAULT state: go to IDLE next edge and clear cnt.
- brk_s=1 in any state (enable irrelevant): go to FAULT and set the fault latch. brk has priority over every other transition.
- FAULT: both outputs inactive. Exit to IDLE only when the latch is clear and brk_s=0.
- A W1C of the latch in the same cycle that brk_s=1: the latch stays set.
- irq_fault_o = 1 for exactly one cycle when the latch goes 0→1 and fault irq enable=1.

## Timing
- Reset values: pwm_hi_o=0, pwm_lo_o=0 (polarity 0), irq_fault_o=0, data_o=0, state=IDLE, latch=0.
- Outputs are flops loaded from the next-state decode XOR polarity, so they change on the same edge as the state register.
- pwm_i rising sampled at edge N: pwm_lo_o goes inactive at edge N+1, and pwm_hi_o goes active at edge N+1+dt_rise. Falling edge is symmetric using dt_fall.
- brk_i to outputs inactive: 3 edges (2 for the synchronizer, 1 for the state). irq_fault_o fires on the same edge as the state change.
- Register writes take effect at the next edge. Read data appears 1 edge after rd_i.

## Structure
- Shared package holds the register offsets DT_CTRL/DT_TIME/DT_STAT, the 3-bit state encodings, and the field bit positions.
- One sub-module, `sync2`: a generic 2-flop synchronizer with asynchronous active-high reset, instantiated for brk_i.

## Test plan
- Reset: both outputs 0, irq 0. Read DT_TIME returns 0x00000000.
- Set DT_TIME=0x0003_0005 and enable=1, then toggle pwm_i: lo drops 1 edge after sampling, hi rises 5 cycles later. On the falling edge, hi drops and lo rises 3 cycles later. Outputs are never both active.
- dt_rise=8 with a 4-cycle pwm_i pulse: hi never asserts, and lo returns active 1 edge after the pulse falls.
- DT_CTRL=0x7 (both polarities active-low): idle level 1/1, and active levels are inverted.
- Assert brk_i in HI_ON with irq enabled: 3 edges later both outputs are inactive and irq pulses once. W1C while brk is held keeps the latch set. Releasing brk then W1C returns the FSM to IDLE, then LO_ON when pwm_i=0.
- Clear enable during DT_RISE: IDLE on the next edge. Assert rst mid-HI_ON: all outputs go to reset values immediately, without waiting for a clock edge.
